// File: rtl/uart_pin_host.sv
// -----------------------------------------------------------------------------
// uart_pin_host
//
// Host-side initiator for the UART wrapper pin interface. It turns a
// valid/ready command stream into cycle-exact pin sequences on
// control_o = {ren_wen[1:0], rate_sel[2:0]} and the 8-bit data pad. Read bytes
// come back on a valid/ready response channel.
//
// Commands (cmd_op):
//   00 set-rate : rate_sel <= cmd_data[2:0] (code 000 is rejected with err)
//   01 write    : one DRIVE cycle, ren_wen=01, pad driven with cmd_data
//                 (byte 0x00 is rejected with err; the wrapper ignores it)
//   10 read     : one DRIVE cycle, ren_wen=10, pad released, then
//                 RD_SAMPLE_DELAY wait cycles; data_i captured on the last one
//   11 clear    : one DRIVE cycle, ren_wen=11, pad driven with 0xFF
// Every pin operation is followed by GAP_CYCLES idle cycles with the bus
// released. Reads then hold rsp_valid/rsp_data until rsp_ready.
//
// Ports:
//   clk, nReset           clock, asynchronous active-low reset
//   cmd_valid/ready/op/data  command channel (cmd_ready high only in IDLE)
//   rsp_valid/ready/data  read response channel
//   err                   one-cycle pulse on a rejected command
//   busy                  high whenever the FSM is not in IDLE
//   control_o             {ren_wen, rate_sel} to the wrapper
//   data_o, data_oe       pad output value and output enable
//   data_i                pad input value
//
// Optional feature macro: UART_HOST_RXPOLL_EN
//   When defined, the block issues an autonomous read after POLL_INTERVAL
//   idle cycles with no cmd_valid. Nonzero bytes are returned as responses,
//   zero bytes are silently dropped.
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module uart_pin_host #(
  parameter logic [2:0] RATE_DEFAULT    = 3'b001,
  parameter int         GAP_CYCLES      = 2,
  parameter int         RD_SAMPLE_DELAY = 1,
  parameter int         POLL_INTERVAL   = 1024
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       err,
  output logic       busy,
  output logic [4:0] control_o,
  output logic [7:0] data_o,
  output logic       data_oe,
  input  logic [7:0] data_i
);

  localparam int MAX_AB  = (GAP_CYCLES > RD_SAMPLE_DELAY) ? GAP_CYCLES : RD_SAMPLE_DELAY;
  localparam int MAX_CNT = (MAX_AB > POLL_INTERVAL) ? MAX_AB : POLL_INTERVAL;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_SAMPLE_DELAY - 1);

  localparam logic [1:0] OP_RATE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [1:0] RW_IDLE  = 2'b00;
  localparam logic [1:0] RW_WRITE = 2'b01;
  localparam logic [1:0] RW_READ  = 2'b10;
  localparam logic [1:0] RW_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_RDWAIT,
    S_GAP,
    S_RESP
  } state_t;

  state_t           r_state;
  logic [2:0]       r_rate;
  logic [1:0]       r_renwen;
  logic [7:0]       r_data_o;
  logic             r_oe;
  logic             r_rsp_valid;
  logic [7:0]       r_rsp_data;
  logic             r_err;
  logic             r_busy;
  logic             r_cmd_ready;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_read;

  logic             w_accept;
  logic             w_drop;

  // Counters never wrap: once all ones they hold.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign w_accept = cmd_valid & r_cmd_ready;

`ifdef UART_HOST_RXPOLL_EN
  localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_INTERVAL - 1);

  logic             r_poll;
  logic [CNT_W-1:0] r_idle_cnt;

  // An autonomous read that returned an empty FIFO (0x00) produces no response.
  assign w_drop = r_poll & (r_rsp_data == 8'h00);
`else
  assign w_drop = 1'b0;
`endif

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state     <= S_IDLE;
      r_rate      <= RATE_DEFAULT;
      r_renwen    <= RW_IDLE;
      r_data_o    <= 8'h00;
      r_oe        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'h00;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_cnt       <= '0;
      r_is_read   <= 1'b0;
`ifdef UART_HOST_RXPOLL_EN
      r_poll      <= 1'b0;
      r_idle_cnt  <= '0;
`endif
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_accept) begin
`ifdef UART_HOST_RXPOLL_EN
            r_idle_cnt <= '0;
            r_poll     <= 1'b0;
`endif
            case (cmd_op)
              OP_RATE: begin
                // Rate 000 would stop the wrapper's baud generator.
                if (cmd_data[2:0] == 3'b000) begin
                  r_err <= 1'b1;
                end else begin
                  r_rate <= cmd_data[2:0];
                end
              end
              OP_WRITE: begin
                if (cmd_data == 8'h00) begin
                  r_err <= 1'b1;
                end else begin
                  r_state     <= S_DRIVE;
                  r_cmd_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_renwen    <= RW_WRITE;
                  r_data_o    <= cmd_data;
                  r_oe        <= 1'b1;
                  r_is_read   <= 1'b0;
                end
              end
              OP_READ: begin
                // Pad released; the wrapper pulls the bus low during the strobe.
                r_state     <= S_DRIVE;
                r_cmd_ready <= 1'b0;
                r_busy      <= 1'b1;
                r_renwen    <= RW_READ;
                r_data_o    <= 8'h00;
                r_oe        <= 1'b0;
                r_is_read   <= 1'b1;
              end
              OP_CLEAR: begin
                r_state     <= S_DRIVE;
                r_cmd_ready <= 1'b0;
                r_busy      <= 1'b1;
                r_renwen    <= RW_CLEAR;
                r_data_o    <= 8'hFF;
                r_oe        <= 1'b1;
                r_is_read   <= 1'b0;
              end
              default: ;
            endcase
          end
`ifdef UART_HOST_RXPOLL_EN
          // A real command on the launch cycle takes priority (branch above).
          else if (r_idle_cnt >= POLL_LAST) begin
            r_idle_cnt  <= '0;
            r_poll      <= 1'b1;
            r_state     <= S_DRIVE;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_renwen    <= RW_READ;
            r_data_o    <= 8'h00;
            r_oe        <= 1'b0;
            r_is_read   <= 1'b1;
          end else begin
            r_idle_cnt <= sat_inc(r_idle_cnt);
          end
`endif
        end

        // The wrapper acts once per cycle while ren_wen is held, so the
        // strobe is always exactly one cycle.
        S_DRIVE: begin
          r_renwen <= RW_IDLE;
          r_data_o <= 8'h00;
          r_oe     <= 1'b0;
          r_cnt    <= '0;
          r_state  <= r_is_read ? S_RDWAIT : S_GAP;
        end

        S_RDWAIT: begin
          if (r_cnt == RD_LAST) begin
            r_rsp_data <= data_i;
            r_cnt      <= '0;
            r_state    <= S_GAP;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end

        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt <= '0;
            if (r_is_read && !w_drop) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state     <= S_IDLE;
              r_cmd_ready <= 1'b1;
              r_busy      <= 1'b0;
            end
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_renwen    <= RW_IDLE;
          r_oe        <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign err       = r_err;
  assign busy      = r_busy;
  assign control_o = {r_renwen, r_rate};
  assign data_o    = r_data_o;
  assign data_oe   = r_oe;

endmodule

// File: tb/tb_uart_pin_host.sv
// -----------------------------------------------------------------------------
// tb_uart_pin_host
//
// Self-checking bench for uart_pin_host (default build, polling disabled).
// A transaction-level model turns each accepted command into the list of
// expected pin cycles, then tracks the response phase. Directed scenarios
// are followed by a long randomized phase.
// -----------------------------------------------------------------------------
module tb_uart_pin_host;

  localparam int         G     = 2;
  localparam int         D     = 1;
  localparam logic [2:0] RDEF  = 3'b001;

  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       err;
  logic       busy;
  logic [4:0] control_o;
  logic [7:0] data_o;
  logic       data_oe;
  logic [7:0] data_i = 8'h00;

  uart_pin_host #(
    .RATE_DEFAULT   (RDEF),
    .GAP_CYCLES     (G),
    .RD_SAMPLE_DELAY(D),
    .POLL_INTERVAL  (1024)
  ) dut (
    .clk      (clk),
    .nReset   (nReset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .err      (err),
    .busy     (busy),
    .control_o(control_o),
    .data_o   (data_o),
    .data_oe  (data_oe),
    .data_i   (data_i)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // One expected pin cycle of an operation in flight.
  typedef struct packed {
    logic [1:0] rw;
    logic       oe;
    logic [7:0] d;
    logic       smp;
  } pin_t;

  pin_t       pq[$];
  bit         m_rd;
  bit         resp_pend;
  logic [7:0] m_rdata;
  logic [2:0] m_rate;
  bit         m_err;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pq.delete();
    m_rd      = 1'b0;
    resp_pend = 1'b0;
    m_rdata   = 8'h00;
    m_rate    = RDEF;
    m_err     = 1'b0;
  endtask

  task automatic push_gap();
    for (int i = 0; i < G; i++) pq.push_back('{2'b00, 1'b0, 8'h00, 1'b0});
  endtask

  // Compare DUT outputs for the current cycle against the model.
  task automatic compare_now();
    logic [1:0] erw;
    logic       eoe;
    logic [7:0] ed;
    logic       ebusy;
    logic       erdy;
    logic       ersp;
    if (pq.size() > 0) begin
      erw = pq[0].rw; eoe = pq[0].oe; ed = pq[0].d;
      ebusy = 1'b1; erdy = 1'b0; ersp = 1'b0;
    end else if (resp_pend) begin
      erw = 2'b00; eoe = 1'b0; ed = 8'h00;
      ebusy = 1'b1; erdy = 1'b0; ersp = 1'b1;
    end else begin
      erw = 2'b00; eoe = 1'b0; ed = 8'h00;
      ebusy = 1'b0; erdy = 1'b1; ersp = 1'b0;
    end
    check("ren_wen",   8'(control_o[4:3]), 8'(erw));
    check("rate_sel",  8'(control_o[2:0]), 8'(m_rate));
    check("data_oe",   8'(data_oe), 8'(eoe));
    if (eoe) check("data_o", data_o, ed);
    check("busy",      8'(busy), 8'(ebusy));
    check("cmd_ready", 8'(cmd_ready), 8'(erdy));
    check("rsp_valid", 8'(rsp_valid), 8'(ersp));
    if (ersp) check("rsp_data", rsp_data, m_rdata);
    check("err",       8'(err), 8'(m_err));
  endtask

  // Advance the model across the clock edge that ends the current cycle.
  task automatic model_step();
    pin_t h;
    m_err = 1'b0;
    if (pq.size() > 0) begin
      h = pq.pop_front();
      if (h.smp) m_rdata = data_i;
      if (pq.size() == 0 && m_rd) begin
        m_rd      = 1'b0;
        resp_pend = 1'b1;
      end
    end else if (resp_pend) begin
      if (rsp_ready) resp_pend = 1'b0;
    end else if (cmd_valid) begin
      case (cmd_op)
        2'b00: begin
          if (cmd_data[2:0] == 3'b000) m_err = 1'b1;
          else m_rate = cmd_data[2:0];
        end
        2'b01: begin
          if (cmd_data == 8'h00) m_err = 1'b1;
          else begin
            pq.push_back('{2'b01, 1'b1, cmd_data, 1'b0});
            push_gap();
          end
        end
        2'b10: begin
          pq.push_back('{2'b10, 1'b0, 8'h00, 1'b0});
          for (int i = 0; i < D; i++) pq.push_back('{2'b00, 1'b0, 8'h00, (i == D - 1)});
          push_gap();
          m_rd = 1'b1;
        end
        default: begin
          pq.push_back('{2'b11, 1'b1, 8'hFF, 1'b0});
          push_gap();
        end
      endcase
    end
  endtask

  task automatic cycle(input bit v, input logic [1:0] op, input logic [7:0] d,
                       input bit rr, input logic [7:0] di);
    @(negedge clk);
    compare_now();
    cmd_valid = v;
    cmd_op    = op;
    cmd_data  = d;
    rsp_ready = rr;
    data_i    = di;
    model_step();
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 2'b00, 8'h00, 1'b0, 8'h00);
  endtask

  initial begin
    model_reset();

    // Reset values while held in reset.
    #12;
    check("rst_control", 8'(control_o), 8'h01);
    check("rst_data_oe", 8'(data_oe), 8'h00);
    check("rst_ready",   8'(cmd_ready), 8'h01);
    check("rst_rsp_vld", 8'(rsp_valid), 8'h00);
    check("rst_busy",    8'(busy), 8'h00);
    check("rst_data_o",  data_o, 8'h00);
    @(negedge clk);
    nReset = 1'b1;
    idle_cycle();
    idle_cycle();

    // Write 0x41.
    cycle(1'b1, 2'b01, 8'h41, 1'b0, 8'h00);
    idle_cycle();
    check("wr_renwen",  8'(control_o[4:3]), 8'h01);
    check("wr_data_o",  data_o, 8'h41);
    check("wr_oe",      8'(data_oe), 8'h01);
    idle_cycle();
    check("wr_gap_oe",  8'(data_oe), 8'h00);
    check("wr_gap_rw",  8'(control_o[4:3]), 8'h00);
    idle_cycle();
    idle_cycle();
    check("wr_ready",   8'(cmd_ready), 8'h01);

    // Read returning 0x5A, response held off for 5 cycles with cmd_valid asserted.
    cycle(1'b1, 2'b10, 8'h00, 1'b0, 8'h5A);
    cycle(1'b0, 2'b00, 8'h00, 1'b0, 8'h5A);
    check("rd_renwen", 8'(control_o[4:3]), 8'h02);
    check("rd_oe",     8'(data_oe), 8'h00);
    cycle(1'b0, 2'b00, 8'h00, 1'b0, 8'h5A);
    check("rd_wait_rw", 8'(control_o[4:3]), 8'h00);
    cycle(1'b0, 2'b00, 8'h00, 1'b0, 8'h00);
    cycle(1'b0, 2'b00, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 2'b01, 8'h33, 1'b0, 8'h00);
      check("rsp_hold_vld",  8'(rsp_valid), 8'h01);
      check("rsp_hold_data", rsp_data, 8'h5A);
      check("rsp_hold_rdy",  8'(cmd_ready), 8'h00);
    end
    cycle(1'b0, 2'b00, 8'h00, 1'b1, 8'h00);
    idle_cycle();
    check("rsp_done_rdy", 8'(cmd_ready), 8'h01);
    check("rsp_done_vld", 8'(rsp_valid), 8'h00);

    // Rejected write 0x00 then rejected set-rate 000 (upper bits ignored).
    cycle(1'b1, 2'b01, 8'h00, 1'b0, 8'h00);
    cycle(1'b1, 2'b00, 8'h08, 1'b0, 8'h00);
    check("err_wr",    8'(err), 8'h01);
    check("err_wr_rw", 8'(control_o[4:3]), 8'h00);
    idle_cycle();
    check("err_rate",  8'(err), 8'h01);
    idle_cycle();
    check("err_clear", 8'(err), 8'h00);
    check("err_rate_kept", 8'(control_o[2:0]), 8'h01);

    // Set-rate 101 then clear.
    cycle(1'b1, 2'b00, 8'h05, 1'b0, 8'h00);
    cycle(1'b1, 2'b11, 8'h00, 1'b0, 8'h00);
    check("rate_101", 8'(control_o), 8'h05);
    idle_cycle();
    check("clr_ctrl", 8'(control_o), 8'h1D);
    check("clr_data", data_o, 8'hFF);
    idle_cycle();
    check("clr_gap",  8'(control_o), 8'h05);
    idle_cycle();
    idle_cycle();

    // Reset asserted during RDWAIT.
    cycle(1'b1, 2'b10, 8'h00, 1'b0, 8'h77);
    cycle(1'b0, 2'b00, 8'h00, 1'b0, 8'h77);
    cycle(1'b0, 2'b00, 8'h00, 1'b0, 8'h77);
    #1 nReset = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    #1;
    check("mid_rst_ctrl", 8'(control_o), 8'h01);
    check("mid_rst_oe",   8'(data_oe), 8'h00);
    check("mid_rst_rdy",  8'(cmd_ready), 8'h01);
    check("mid_rst_busy", 8'(busy), 8'h00);
    check("mid_rst_vld",  8'(rsp_valid), 8'h00);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    nReset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle_cycle();
      check("post_rst_vld", 8'(rsp_valid), 8'h00);
    end
    check("post_rst_rate", 8'(control_o[2:0]), 8'h01);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] d;
      logic [7:0] di;
      d  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      di = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      cycle(($urandom_range(0, 1) == 1), 2'($urandom), d,
            ($urandom_range(0, 2) != 0), di);
    end
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
